dm_port_arbiter: RTL and testbench

Two-requester arbiter for the single-ported data memory of the single-cycle core. Shares the memory between the CPU load/store path and an external port (program/data loader or debug access). Grants round-robin on contention. Stalls the CPU through `cpu_stall`, which the controller ANDs into its PC enable, until its access completes.

---
 rtl/dm_port_arbiter.sv | 125 ++++++++++++
 tb/tb_dm_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the CPU
// load/store path and an external loader/debug port.
module dm_port_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    EXT_RD = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // last winner: 0 = CPU, 1 = EXT

  logic cpu_req;
  logic cpu_win;
  logic ext_win;

  assign cpu_req = cpu_rd | cpu_wr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // On a tie the side that did not win last time is served.
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (state_q == IDLE) begin
      cpu_win = cpu_req & (~ext_req | last_q);
      ext_win = ext_req & (~cpu_req | ~last_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    ext_gnt    = 1'b0;
    ext_rdata  = '0;
    ext_rvalid = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    if (!rst) begin
      state_d = IDLE;
      last_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_win) begin
            last_d   = 1'b0;
            mem_addr = cpu_addr;
            if (cpu_wr) begin
              mem_we    = 1'b1;
              mem_wdata = cpu_wdata;
            end else begin
              mem_re  = 1'b1;
              state_d = CPU_RD;
            end
          end else if (ext_win) begin
            last_d   = 1'b1;
            ext_gnt  = 1'b1;
            mem_addr = ext_addr;
            if (ext_we) begin
              mem_we    = 1'b1;
              mem_wdata = ext_wdata;
            end else begin
              mem_re  = 1'b1;
              state_d = EXT_RD;
            end
          end
          // Only a granted CPU store lets the CPU proceed from IDLE.
          cpu_stall = cpu_req & ~(cpu_win & cpu_wr);
        end
        CPU_RD: begin
          cpu_rdata = mem_rdata;
          state_d   = IDLE;
        end
        EXT_RD: begin
          ext_rvalid = 1'b1;
          ext_rdata  = mem_rdata;
          cpu_stall  = cpu_req;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a one-cycle-latency memory model.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [11:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];

  int checks = 0;
  int failures = 0;

  dm_port_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cpu_rdata, cpu_stall, ext_gnt, ext_rdata, ext_rvalid,
                mem_addr, mem_wdata, mem_we, mem_re});
  endfunction

  // Common strobe/grant/stall view: {mem_we, mem_re, ext_gnt, ext_rvalid, cpu_stall}
  function automatic logic [63:0] ctl();
    return 64'({mem_we, mem_re, ext_gnt, ext_rvalid, cpu_stall});
  endfunction

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 12'h010;
    ext_req = 1'b1; ext_addr = 12'h3FF;

    // Reset held with both sides requesting: everything quiet.
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("reset_outs", all_outs(), 64'd0);
      tick();
    end
    rst = 1'b1;

    // First tie after reset goes to the CPU.
    sample();
    chk("rel_ctl", ctl(), 64'b01001);
    chk("rel_addr", 64'(mem_addr), 64'h010);
    tick();
    sample();
    chk("rel_cpurd_ctl", ctl(), 64'b00000);
    tick();
    idle_inputs();
    sample();
    chk("idle_outs", all_outs(), 64'd0);
    tick();

    // Ext write preloads 0x3FF with 0xC3 (granted in the request cycle).
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h3FF; ext_wdata = 8'hC3;
    sample();
    chk("extwr_ctl", ctl(), 64'b10100);
    chk("extwr_data", 64'({mem_addr, mem_wdata}), 64'h3FFC3);
    tick();
    idle_inputs();

    // CPU store 0x5A to 0x010: no stall.
    cpu_wr = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h5A;
    sample();
    chk("cpust_ctl", ctl(), 64'b10000);
    chk("cpust_data", 64'({mem_addr, mem_wdata}), 64'h0105A);
    tick();

    // CPU load from 0x010: one stall cycle, then data.
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_wdata = '0;
    sample();
    chk("cpuld_t0", ctl(), 64'b01001);
    tick();
    sample();
    chk("cpuld_t1", ctl(), 64'b00000);
    chk("cpuld_data", 64'(cpu_rdata), 64'h5A);
    tick();
    idle_inputs();

    // Ext read of 0x3FF: gnt at t, rvalid+data at t+1, both single-cycle.
    ext_req = 1'b1; ext_addr = 12'h3FF;
    sample();
    chk("extrd_t0", ctl(), 64'b01100);
    chk("extrd_addr", 64'(mem_addr), 64'h3FF);
    tick();
    ext_req = 1'b0;
    sample();
    chk("extrd_t1", ctl(), 64'b00010);
    chk("extrd_data", 64'(ext_rdata), 64'hC3);
    tick();
    sample();
    chk("extrd_t2", all_outs(), 64'd0);
    tick();

    // Continuous contention: CPU load vs ext read, six grants alternating.
    cpu_rd = 1'b1; cpu_addr = 12'h010;
    ext_req = 1'b1; ext_addr = 12'h3FF;
    for (int i = 0; i < 12; i++) begin
      sample();
      case (i % 4)
        0: begin
          chk("cont_cpu_gnt", ctl(), 64'b01001);
          chk("cont_cpu_addr", 64'(mem_addr), 64'h010);
        end
        1: begin
          chk("cont_cpu_data_ctl", ctl(), 64'b00000);
          chk("cont_cpu_data", 64'(cpu_rdata), 64'h5A);
        end
        2: begin
          chk("cont_ext_gnt", ctl(), 64'b01101);
          chk("cont_ext_addr", 64'(mem_addr), 64'h3FF);
        end
        default: begin
          chk("cont_ext_rv", ctl(), 64'b00011);
          chk("cont_ext_data", 64'(ext_rdata), 64'hC3);
        end
      endcase
      tick();
    end
    idle_inputs();

    // CPU load arriving during EXT_RD: two stall cycles, data on the third.
    ext_req = 1'b1; ext_addr = 12'h3FF;
    sample();
    chk("late_extgnt", ctl(), 64'b01100);
    tick();
    ext_req = 1'b0; ext_addr = '0;
    cpu_rd = 1'b1; cpu_addr = 12'h010;
    sample();
    chk("late_stall1", ctl(), 64'b00011);
    tick();
    sample();
    chk("late_stall2", ctl(), 64'b01001);
    tick();
    sample();
    chk("late_data_ctl", ctl(), 64'b00000);
    chk("late_data", 64'(cpu_rdata), 64'h5A);
    tick();
    idle_inputs();

    // Back-to-back writes from both sides with no dead cycle.
    cpu_wr = 1'b1; cpu_addr = 12'h030; cpu_wdata = 8'hA1;
    sample();
    chk("b2b_cpuwr", ctl(), 64'b10000);
    tick();
    idle_inputs();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h031; ext_wdata = 8'hB2;
    sample();
    chk("b2b_extwr", ctl(), 64'b10100);
    chk("b2b_extwr_data", 64'({mem_addr, mem_wdata}), 64'h031B2);
    tick();
    idle_inputs();
    cpu_rd = 1'b1; cpu_addr = 12'h031;
    sample();
    chk("rb_cpu_gnt", ctl(), 64'b01001);
    tick();
    sample();
    chk("rb_cpu_data", 64'(cpu_rdata), 64'hB2);
    tick();
    idle_inputs();
    ext_req = 1'b1; ext_addr = 12'h030;
    sample();
    chk("rb_ext_gnt", ctl(), 64'b01100);
    tick();
    ext_req = 1'b0;
    sample();
    chk("rb_ext_data", 64'({ext_rvalid, ext_rdata}), 64'h1A1);
    tick();
    idle_inputs();

    // Store and load together count as a store.
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h040; cpu_wdata = 8'h3C;
    sample();
    chk("rdwr_is_store", ctl(), 64'b10000);
    tick();
    idle_inputs();

    // Cancelled ext request leaves last alone; the later tie goes to EXT.
    cpu_rd = 1'b1; cpu_addr = 12'h040;
    sample();
    chk("cancel_cpu_gnt", ctl(), 64'b01001);
    tick();
    ext_req = 1'b1; ext_addr = 12'h3FF;
    sample();
    chk("cancel_no_gnt", ctl(), 64'b00000);
    chk("cancel_rdata", 64'(cpu_rdata), 64'h3C);
    tick();
    cpu_rd = 1'b0; ext_req = 1'b0;
    sample();
    chk("cancel_idle", all_outs(), 64'd0);
    tick();
    cpu_rd = 1'b1; ext_req = 1'b1;
    sample();
    chk("tie_ext_wins", ctl(), 64'b01101);
    tick();

    // Reset during EXT_RD: response dropped, CPU wins the next tie.
    rst = 1'b0;
    sample();
    chk("rst_extrd_outs", all_outs(), 64'd0);
    tick();
    rst = 1'b1;
    sample();
    chk("post_rst_ctl", ctl(), 64'b01001);
    chk("post_rst_addr", 64'(mem_addr), 64'h040);
    tick();
    sample();
    chk("post_rst_data", 64'({ext_rvalid, cpu_rdata}), 64'h03C);
    tick();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
